// File: rtl/spi_pattern_pkg.sv
// Shared constants for the SPI MISO pattern source: MISO mode encodings and free-running counter width.
package spi_pattern_pkg;

    localparam logic [1:0] MODE_SQUARE  = 2'd0;
    localparam logic [1:0] MODE_COUNT   = 2'd1;
    localparam logic [1:0] MODE_ECHO    = 2'd2;
    localparam logic [1:0] MODE_MONITOR = 2'd3;

    localparam int CTR_W = 32;

endpackage

// File: rtl/spi_miso_pattern_sync_ff.sv
// Multi-stage 1-bit synchroniser with asynchronous active-high reset to a selectable idle level.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {STAGES{RST_VAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_miso_pattern.sv
// SPI-slave test-pattern source: square / frame-counter / MOSI-echo / monitor on MISO, plus MOSI word receive.
// Optional MISO readback contention check is built when SPI_MISO_READBACK_EN is defined.
module spi_miso_pattern #(
    parameter int WIDTH       = 8,
    parameter int DIV_W       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SSEL,
    input  logic             SCK,
    input  logic             MOSI,
    inout  wire              MISO,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             mismatch
);

    import spi_pattern_pkg::*;

    localparam int              BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST = BC_W'(WIDTH - 1);

    logic             ssel_s, sck_s, mosi_s;
    logic             ssel_d, sck_d;
    logic [CTR_W-1:0] ctr;
    logic [WIDTH-1:0] frame_cnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] rx_next;
    logic [BC_W-1:0]  bit_cnt;
    logic [1:0]       mode_q;
    logic             echo_bit;
    logic             word_done;
    logic             miso_bit;
    logic             oe;
    logic             ssel_fall, ssel_rise, sck_rise, sck_fall;

    // SSEL idles high so reset release never looks like a frame start.
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (.clk(clk), .rst(rst), .d(SSEL), .q(ssel_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d(SCK),  .q(sck_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(MOSI), .q(mosi_s));

    // A synced SSEL rise takes priority over any SCK edge seen in the same clk.
    assign ssel_fall = ssel_d & ~ssel_s;
    assign ssel_rise = ~ssel_d & ssel_s;
    assign sck_rise  = busy & ~ssel_rise & ~sck_d & sck_s;
    assign sck_fall  = busy & ~ssel_rise & sck_d & ~sck_s;
    assign rx_next   = {rx_sr[WIDTH-2:0], mosi_s};

    // rx_valid is a one-clk strobe with no backpressure; rx_data holds until the next complete word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssel_d    <= 1'b1;
            sck_d     <= 1'b0;
            ctr       <= '0;
            frame_cnt <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            mode_q    <= MODE_MONITOR;
            echo_bit  <= 1'b0;
            word_done <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ctr      <= ctr + 1'b1;
            ssel_d   <= ssel_s;
            sck_d    <= sck_s;
            rx_valid <= 1'b0;
            if (ssel_fall) begin
                mode_q    <= mode;
                bit_cnt   <= '0;
                tx_sr     <= frame_cnt;
                rx_sr     <= '0;
                echo_bit  <= 1'b0;
                word_done <= 1'b0;
                busy      <= 1'b1;
            end else if (ssel_rise) begin
                bit_cnt   <= '0;
                rx_sr     <= '0;
                word_done <= 1'b0;
                busy      <= 1'b0;
            end else if (sck_rise) begin
                rx_sr    <= rx_next;
                echo_bit <= mosi_s;
                if (bit_cnt == LAST) begin
                    bit_cnt   <= '0;
                    rx_data   <= rx_next;
                    rx_valid  <= 1'b1;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (sck_fall && (mode_q == MODE_COUNT)) begin
                // The fall after the last bit of a word preloads the next frame number.
                if (word_done) begin
                    tx_sr     <= frame_cnt + 1'b1;
                    frame_cnt <= frame_cnt + 1'b1;
                    word_done <= 1'b0;
                end else begin
                    tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        miso_bit = 1'b0;
        case (mode_q)
            MODE_SQUARE: miso_bit = ctr[div];
            MODE_COUNT:  miso_bit = tx_sr[WIDTH-1];
            MODE_ECHO:   miso_bit = echo_bit;
            default:     miso_bit = 1'b0;
        endcase
    end

    // Raw SSEL in the enable releases the pin without synchroniser delay.
    assign oe   = ~SSEL & busy & (mode_q != MODE_MONITOR);
    assign MISO = oe ? miso_bit : 1'bz;

`ifdef SPI_MISO_READBACK_EN
    logic                   miso_rb_s;
    logic [SYNC_STAGES-1:0] drv_dly;
    logic [SYNC_STAGES-1:0] oe_dly;
    logic                   differ;
    logic                   differ_q;
    logic                   mismatch_q;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rb (.clk(clk), .rst(rst), .d(MISO), .q(miso_rb_s));

    // Compare the pin against what was driven SYNC_STAGES clk ago, matching the sampler latency.
    assign differ = oe & oe_dly[SYNC_STAGES-1] & (miso_rb_s != drv_dly[SYNC_STAGES-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drv_dly    <= '0;
            oe_dly     <= '0;
            differ_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            drv_dly  <= {drv_dly[SYNC_STAGES-2:0], miso_bit};
            oe_dly   <= {oe_dly[SYNC_STAGES-2:0], oe};
            differ_q <= differ;
            if (ssel_fall) begin
                mismatch_q <= 1'b0;
            end else if (differ && differ_q) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule
